// File: rtl/gs232c_bp_pkg.sv
// Shared branch-predictor definitions: hint field layout, FSM encoding,
// queue entry format and the static taken prediction.
package gs232c_bp_pkg;

   localparam int unsigned HintValidBit = 0;
   localparam int unsigned HintCntLsb   = 1;
   localparam int unsigned HintCntMsb   = 2;
   localparam int unsigned HintIdxLsb   = 3;
   localparam int unsigned HintIdxMsb   = 5;
   localparam int unsigned HintBropsLsb = 6;
   localparam int unsigned HintBropsMsb = 9;
   localparam int unsigned HintJrraBit  = 10;
   localparam int unsigned HintLinkBit  = 11;
   localparam int unsigned HintDofsLsb  = 12;
   localparam int unsigned HintDofsMsb  = 13;
   localparam int unsigned HintJropBit  = 14;
   localparam int unsigned HintBropBit  = 15;

   localparam int unsigned EntryW = 80;

   typedef enum logic [0:0] {
      StInit = 1'b0,
      StRun  = 1'b1
   } bp_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [15:0] hint;
      logic [31:0] target;
   } brq_entry_t;

   // Conditional branches use the counter MSB; anything else with a valid hint is taken.
   function automatic logic pred_taken(input logic [15:0] hint);
      return hint[HintValidBit] && (!hint[HintBropBit] || hint[HintCntMsb]);
   endfunction

endpackage

// File: rtl/gs232c_brq_fifo.sv
// Branch resolve queue storage: circular buffer with synchronous flush.
module gs232c_brq_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 80
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];

   // Flush wins over both operations; the popped head is still read out this cycle.
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/gs232c_brq.sv
// Branch resolve queue: holds predicted fetch groups until resolution, compares
// prediction against outcome and emits predictor update / mispredict pulses.
module gs232c_brq
   import gs232c_bp_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned INIT_N = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fe_valid,
   input  logic [31:0] fe_pc,
   input  logic [15:0] fe_hint,
   input  logic [31:0] fe_target,
   output logic        fe_ready,
   input  logic        iq_cancel,
   input  logic        rs_valid,
   input  logic        rs_brop,
   input  logic        rs_jrop,
   input  logic        rs_taken,
   input  logic [31:0] rs_target,
   input  logic [3:0]  rs_brops_raw,
   input  logic [1:0]  rs_dofs,
   input  logic        rs_link,
   input  logic        rs_jrra,
   input  logic [29:0] rs_link_pc,
   output logic        pr_valid,
   output logic        pr_cancel,
   output logic        pr_taken,
   output logic [3:0]  pr_takens,
   output logic [31:0] pr_pc,
   output logic [29:0] pr_base,
   output logic [15:0] pr_hint,
   output logic [31:0] pr_target,
   output logic        pr_brop,
   output logic        pr_jrop,
   output logic        pr_jrra,
   output logic        pr_link,
   output logic [29:0] pr_link_pc,
   output logic [1:0]  pr_dofs,
   output logic [3:0]  pr_brops,
   output logic [3:0]  pr_brops_raw,
   output logic        raminit_valid,
   output logic [7:0]  raminit_index
);

   localparam int unsigned CntW = (INIT_N > 1) ? $clog2(INIT_N) : 1;

   bp_state_e       state_q, state_d;
   logic [CntW-1:0] init_cnt_q, init_cnt_d;
   logic            init_last;

   logic            fifo_full, fifo_empty;
   logic [EntryW-1:0] fifo_rdata;
   brq_entry_t      head;
   brq_entry_t      fe_entry;
   logic            head_pred_taken;
   logic            mispredict;
   logic            pop, push, flush;

   // ---------------------------------------------------------------- init FSM
   assign init_last = (init_cnt_q == CntW'(INIT_N - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StInit;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = '0;
      unique case (state_q)
         StInit: begin
            if (init_last) begin
               state_d = StRun;
            end else begin
               init_cnt_d = init_cnt_q + 1'b1;
            end
         end
         StRun: state_d = StRun;
      endcase
   end

   always_comb begin
      raminit_valid = 1'b0;
      raminit_index = '0;
      fe_ready      = 1'b0;
      unique case (state_q)
         StInit: begin
            // Held low during reset so the sweep reads as starting on release.
            raminit_valid = !reset;
            raminit_index = 8'(init_cnt_q);
         end
         StRun: fe_ready = !fifo_full;
      endcase
   end

   // ---------------------------------------------------------------- queue
   assign fe_entry = '{pc: fe_pc, hint: fe_hint, target: fe_target};
   assign head     = brq_entry_t'(fifo_rdata);

   assign head_pred_taken = pred_taken(head.hint);
   assign mispredict = (head_pred_taken != rs_taken) ||
                       (head_pred_taken && rs_taken && (head.target != rs_target));

   assign pop   = rs_valid && !fifo_empty;
   assign flush = iq_cancel || (pop && mispredict);
   assign push  = fe_valid && fe_ready && !flush;

   gs232c_brq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EntryW)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .flush_i (flush),
      .push_i  (push),
      .wdata_i (fe_entry),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // ---------------------------------------------------------------- update outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pr_valid     <= 1'b0;
         pr_cancel    <= 1'b0;
         pr_taken     <= 1'b0;
         pr_takens    <= '0;
         pr_pc        <= '0;
         pr_base      <= '0;
         pr_hint      <= '0;
         pr_target    <= '0;
         pr_brop      <= 1'b0;
         pr_jrop      <= 1'b0;
         pr_jrra      <= 1'b0;
         pr_link      <= 1'b0;
         pr_link_pc   <= '0;
         pr_dofs      <= '0;
         pr_brops     <= '0;
         pr_brops_raw <= '0;
      end else begin
         pr_valid  <= pop;
         pr_cancel <= pop && mispredict;
         if (pop) begin
            pr_taken     <= rs_taken;
            pr_takens    <= rs_taken ? (4'b0001 << rs_dofs) : 4'b0000;
            pr_pc        <= head.pc;
            pr_base      <= head.pc[31:2];
            pr_hint      <= head.hint;
            pr_target    <= rs_target;
            pr_brop      <= rs_brop;
            pr_jrop      <= rs_jrop;
            pr_jrra      <= rs_jrra;
            pr_link      <= rs_link;
            pr_link_pc   <= rs_link_pc;
            pr_dofs      <= rs_dofs;
            pr_brops     <= rs_brops_raw;
            pr_brops_raw <= rs_brops_raw;
         end
      end
   end

endmodule

// File: tb/tb_gs232c_brq.sv
// Directed bench for gs232c_brq: init sweep, resolve vector table, and
// hand-written full / flush / cancel / reset sequences.
module tb_gs232c_brq;

   logic        clock = 1'b0;
   logic        reset;
   logic        fe_valid;
   logic [31:0] fe_pc;
   logic [15:0] fe_hint;
   logic [31:0] fe_target;
   logic        fe_ready;
   logic        iq_cancel;
   logic        rs_valid, rs_brop, rs_jrop, rs_taken, rs_link, rs_jrra;
   logic [31:0] rs_target;
   logic [3:0]  rs_brops_raw;
   logic [1:0]  rs_dofs;
   logic [29:0] rs_link_pc;
   logic        pr_valid, pr_cancel, pr_taken, pr_brop, pr_jrop, pr_jrra, pr_link;
   logic [3:0]  pr_takens, pr_brops, pr_brops_raw;
   logic [31:0] pr_pc, pr_target;
   logic [29:0] pr_base, pr_link_pc;
   logic [15:0] pr_hint;
   logic [1:0]  pr_dofs;
   logic        raminit_valid;
   logic [7:0]  raminit_index;

   int checks = 0;
   int errors = 0;

   gs232c_brq #(
      .DEPTH  (4),
      .INIT_N (256)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .fe_valid      (fe_valid),
      .fe_pc         (fe_pc),
      .fe_hint       (fe_hint),
      .fe_target     (fe_target),
      .fe_ready      (fe_ready),
      .iq_cancel     (iq_cancel),
      .rs_valid      (rs_valid),
      .rs_brop       (rs_brop),
      .rs_jrop       (rs_jrop),
      .rs_taken      (rs_taken),
      .rs_target     (rs_target),
      .rs_brops_raw  (rs_brops_raw),
      .rs_dofs       (rs_dofs),
      .rs_link       (rs_link),
      .rs_jrra       (rs_jrra),
      .rs_link_pc    (rs_link_pc),
      .pr_valid      (pr_valid),
      .pr_cancel     (pr_cancel),
      .pr_taken      (pr_taken),
      .pr_takens     (pr_takens),
      .pr_pc         (pr_pc),
      .pr_base       (pr_base),
      .pr_hint       (pr_hint),
      .pr_target     (pr_target),
      .pr_brop       (pr_brop),
      .pr_jrop       (pr_jrop),
      .pr_jrra       (pr_jrra),
      .pr_link       (pr_link),
      .pr_link_pc    (pr_link_pc),
      .pr_dofs       (pr_dofs),
      .pr_brops      (pr_brops),
      .pr_brops_raw  (pr_brops_raw),
      .raminit_valid (raminit_valid),
      .raminit_index (raminit_index)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic [15:0] hint;
      logic [31:0] tgt;
      logic        taken;
      logic [31:0] rs_tgt;
      logic [1:0]  dofs;
      logic [3:0]  braw;
      logic [29:0] lpc;
      logic        exp_cancel;
      logic [3:0]  exp_takens;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_enq(input logic [31:0] pc, input logic [15:0] hint, input logic [31:0] tgt);
      fe_valid  = 1'b1;
      fe_pc     = pc;
      fe_hint   = hint;
      fe_target = tgt;
      check("enq_ready", fe_ready, 1'b1);
      tick();
      fe_valid = 1'b0;
   endtask

   task automatic do_pop(input logic taken, input logic [31:0] tgt, input logic [1:0] dofs);
      rs_valid  = 1'b1;
      rs_taken  = taken;
      rs_target = tgt;
      rs_dofs   = dofs;
      tick();
      rs_valid = 1'b0;
   endtask

   initial begin
      int n_valid;
      int idx_bad;
      int rdy_bad;
      vecs[0] = '{32'h1000, 16'h0005, 32'h2000, 1'b1, 32'h2000, 2'd0, 4'h3, 30'h11, 1'b0, 4'b0001};
      vecs[1] = '{32'h1000, 16'h0005, 32'h2000, 1'b1, 32'h3000, 2'd0, 4'h0, 30'h22, 1'b1, 4'b0001};
      vecs[2] = '{32'h2004, 16'h0001, 32'h2100, 1'b0, 32'h2100, 2'd1, 4'ha, 30'h33, 1'b1, 4'b0000};
      vecs[3] = '{32'h300c, 16'h8001, 32'h3100, 1'b0, 32'h0000, 2'd3, 4'h5, 30'h44, 1'b0, 4'b0000};
      vecs[4] = '{32'h4000, 16'h8005, 32'h5000, 1'b1, 32'h5000, 2'd2, 4'hf, 30'h3fffffff, 1'b0, 4'b0100};
      vecs[5] = '{32'h5008, 16'h0000, 32'h6000, 1'b1, 32'h6000, 2'd1, 4'h1, 30'h55, 1'b1, 4'b0010};
      vecs[6] = '{32'h6000, 16'h8001, 32'h7000, 1'b1, 32'h7000, 2'd3, 4'h8, 30'h66, 1'b1, 4'b1000};
      vecs[7] = '{32'h7000, 16'h0005, 32'h7100, 1'b0, 32'h7100, 2'd0, 4'h2, 30'h77, 1'b1, 4'b0000};

      reset = 1'b1;
      fe_valid = 0; fe_pc = 0; fe_hint = 0; fe_target = 0; iq_cancel = 0;
      rs_valid = 0; rs_brop = 0; rs_jrop = 0; rs_taken = 0; rs_link = 0; rs_jrra = 0;
      rs_target = 0; rs_brops_raw = 0; rs_dofs = 0; rs_link_pc = 0;

      #2;
      check("rst_raminit_valid", raminit_valid, 1'b0);
      check("rst_pr_valid", pr_valid, 1'b0);
      check("rst_fe_ready", fe_ready, 1'b0);
      tick();
      reset = 1'b0;
      #1;

      // Init sweep: 256 cycles of valid with counting index, no fetch acceptance.
      n_valid = 0; idx_bad = 0; rdy_bad = 0;
      for (int i = 0; i < 260; i++) begin
         if (raminit_valid) begin
            n_valid++;
            if (raminit_index != 8'(i)) idx_bad++;
         end else if (raminit_index != 8'd0) begin
            idx_bad++;
         end
         if (fe_ready != (i >= 256)) rdy_bad++;
         if (raminit_valid != (i < 256)) rdy_bad++;
         tick();
      end
      check("init_valid_cycles", n_valid, 256);
      check("init_index_seq", idx_bad, 0);
      check("init_ready_timing", rdy_bad, 0);
      check("run_fe_ready", fe_ready, 1'b1);

      // Resolve vector table.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] ib;
         ib = 3'(i);
         rs_brops_raw = vecs[i].braw;
         rs_link_pc   = vecs[i].lpc;
         rs_jrop      = ib[0];
         rs_jrra      = ib[1];
         rs_link      = ib[2];
         rs_brop      = ib[0] ^ ib[1];
         do_enq(vecs[i].pc, vecs[i].hint, vecs[i].tgt);
         do_pop(vecs[i].taken, vecs[i].rs_tgt, vecs[i].dofs);
         check("vec_valid", pr_valid, 1'b1);
         check("vec_cancel", pr_cancel, vecs[i].exp_cancel);
         check("vec_takens", pr_takens, vecs[i].exp_takens);
         check("vec_taken", pr_taken, vecs[i].taken);
         check("vec_pc", pr_pc, vecs[i].pc);
         check("vec_base", pr_base, vecs[i].pc[31:2]);
         check("vec_hint", pr_hint, vecs[i].hint);
         check("vec_target", pr_target, vecs[i].rs_tgt);
         check("vec_dofs", pr_dofs, vecs[i].dofs);
         check("vec_brops", pr_brops, vecs[i].braw);
         check("vec_brops_raw", pr_brops_raw, vecs[i].braw);
         check("vec_link_pc", pr_link_pc, vecs[i].lpc);
         check("vec_flags", {pr_brop, pr_jrop, pr_jrra, pr_link},
               {ib[0] ^ ib[1], ib[0], ib[1], ib[2]});
         tick();
         check("vec_valid_pulse", pr_valid, 1'b0);
         check("vec_cancel_pulse", pr_cancel, 1'b0);
         check("vec_pc_hold", pr_pc, vecs[i].pc);
      end
      check("vec0_base_literal", 64'(vecs[0].pc[31:2]), 64'h400);

      // Full queue: a same-cycle pop does not make room for that cycle's enqueue.
      for (int k = 0; k < 4; k++) begin
         do_enq(32'h100 + 32'(4 * k), 16'h0005, 32'h1100 + 32'(4 * k));
      end
      check("full_ready", fe_ready, 1'b0);
      fe_valid = 1'b1; fe_pc = 32'h110; fe_hint = 16'h0005; fe_target = 32'h1110;
      rs_valid = 1'b1; rs_taken = 1'b1; rs_target = 32'h1100; rs_dofs = 2'd0;
      check("full_pop_ready", fe_ready, 1'b0);
      tick();
      rs_valid = 1'b0;
      check("full_pop_valid", pr_valid, 1'b1);
      check("full_pop_pc", pr_pc, 32'h100);
      check("full_pop_cancel", pr_cancel, 1'b0);
      check("full_after_ready", fe_ready, 1'b1);
      tick();
      fe_valid = 1'b0;
      check("full_refill_ready", fe_ready, 1'b0);
      for (int k = 1; k < 5; k++) begin
         do_pop(1'b1, 32'h1100 + 32'(4 * k), 2'd0);
         check("fifo_order_valid", pr_valid, 1'b1);
         check("fifo_order_pc", pr_pc, 32'h100 + 32'(4 * k));
         check("fifo_order_cancel", pr_cancel, 1'b0);
      end
      do_pop(1'b1, 32'h0, 2'd0);
      check("drained_pop_valid", pr_valid, 1'b0);

      // iq_cancel with simultaneous enqueue and pop.
      do_enq(32'h200, 16'h0005, 32'h1200);
      do_enq(32'h204, 16'h0005, 32'h1204);
      iq_cancel = 1'b1;
      fe_valid = 1'b1; fe_pc = 32'h208; fe_hint = 16'h0005; fe_target = 32'h1208;
      rs_valid = 1'b1; rs_taken = 1'b1; rs_target = 32'h1200; rs_dofs = 2'd0;
      tick();
      iq_cancel = 1'b0; fe_valid = 1'b0; rs_valid = 1'b0;
      check("iqc_valid", pr_valid, 1'b1);
      check("iqc_pc", pr_pc, 32'h200);
      check("iqc_cancel", pr_cancel, 1'b0);
      do_pop(1'b1, 32'h1204, 2'd0);
      check("iqc_empty", pr_valid, 1'b0);
      do_pop(1'b1, 32'h1208, 2'd0);
      check("iqc_not_stored", pr_valid, 1'b0);

      // Mispredict flushes the rest and drops the same-cycle enqueue.
      do_enq(32'h300, 16'h0005, 32'h1300);
      do_enq(32'h304, 16'h0005, 32'h1304);
      fe_valid = 1'b1; fe_pc = 32'h308; fe_hint = 16'h0005; fe_target = 32'h1308;
      rs_valid = 1'b1; rs_taken = 1'b1; rs_target = 32'h3000; rs_dofs = 2'd0;
      tick();
      fe_valid = 1'b0; rs_valid = 1'b0;
      check("mp_valid", pr_valid, 1'b1);
      check("mp_cancel", pr_cancel, 1'b1);
      check("mp_target", pr_target, 32'h3000);
      check("mp_pc", pr_pc, 32'h300);
      do_pop(1'b1, 32'h1304, 2'd0);
      check("mp_flushed", pr_valid, 1'b0);
      check("mp_hold_pc", pr_pc, 32'h300);
      check("mp_hold_target", pr_target, 32'h3000);

      // Empty pop with taken/dofs must not update anything.
      do_pop(1'b1, 32'h9999, 2'd2);
      check("empty_pop_valid", pr_valid, 1'b0);
      check("empty_pop_takens_hold", pr_takens, 4'b0001);

      // Reset mid-RUN restarts the sweep and discards queue contents.
      do_enq(32'h400, 16'h0005, 32'h1400);
      reset = 1'b1;
      #1;
      check("mrst_pr_pc", pr_pc, 32'h0);
      check("mrst_pr_target", pr_target, 32'h0);
      check("mrst_raminit_valid", raminit_valid, 1'b0);
      check("mrst_fe_ready", fe_ready, 1'b0);
      tick();
      reset = 1'b0;
      #1;
      check("mrst_sweep_valid", raminit_valid, 1'b1);
      check("mrst_sweep_idx0", raminit_index, 8'd0);
      for (int i = 0; i < 3; i++) tick();
      check("mrst_sweep_idx3", raminit_index, 8'd3);
      for (int i = 0; i < 253; i++) tick();
      check("mrst_run_ready", fe_ready, 1'b1);
      do_pop(1'b1, 32'h1400, 2'd0);
      check("mrst_queue_discarded", pr_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
